// File: rtl/ahb_ap.sv
// ahb_ap: AHB-Lite access port that executes debug command words from the send FIFO
// as single-beat transfers; optional HREADY watchdog enabled by defining AHB_AP_TIMEOUT_EN.
module ahb_ap #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_WORD       = 32'hBADC0FFE,
    parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic [DATA_WIDTH-1:0] send_rdata,
    input  logic                  send_empty,
    output logic                  send_rinc,
    output logic [DATA_WIDTH-1:0] read_wdata,
    input  logic                  read_full,
    output logic                  read_winc,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic                  err_clr,
    output logic                  busy,
    output logic                  err,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_FETCH, S_BEAT_WAIT, S_ADDR_PH, S_DATA_PH, S_ABORT
    } state_t;

    state_t                state_q;
    logic                  write_q;
    logic                  incr_q;
    logic [1:0]            size_q;
    logic [8:0]            remaining_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic                  err_q;

    logic tmo_hit;
    logic beat_done;
    logic beat_err;
    logic abort_xfer;
    logic err_set;
    logic unused_hdr;

    assign unused_hdr = ^{send_rdata[30], send_rdata[26:8]};

`ifdef AHB_AP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    // The beat is abandoned on the TIMEOUT_CYCLES-th consecutive HREADY-low cycle.
    assign tmo_hit = (state_q == S_DATA_PH) && !HREADY &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!nRST) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == S_DATA_PH) && !HREADY && !tmo_hit)
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            else
                tmo_cnt_q <= '0;
            timeout_q <= tmo_hit | (timeout_q & ~err_clr);
        end
    end

    assign timeout = timeout_q;
`else
    logic [31:0] unused_tmo;

    assign unused_tmo = 32'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign beat_done  = (state_q == S_DATA_PH) && (HREADY || tmo_hit);
    assign beat_err   = (HREADY && HRESP) || tmo_hit;
    assign abort_xfer = (state_q == S_ABORT) && (write_q ? !send_empty : !read_full);
    assign err_set    = ((state_q == S_ADDR_FETCH) && !send_empty && (size_q == 2'b11)) ||
                        (beat_done && beat_err);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            incr_q      <= 1'b0;
            size_q      <= 2'b00;
            remaining_q <= '0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= err_set | (err_q & ~err_clr);
            case (state_q)
                S_IDLE: begin
                    if (!send_empty) begin
                        write_q     <= send_rdata[31];
                        size_q      <= send_rdata[29:28];
                        incr_q      <= send_rdata[27];
                        remaining_q <= {1'b0, send_rdata[7:0]} + 9'd1;
                        state_q     <= S_ADDR_FETCH;
                    end
                end
                S_ADDR_FETCH: begin
                    if (!send_empty) begin
                        haddr_q <= send_rdata[ADDR_WIDTH-1:0];
                        state_q <= (size_q == 2'b11) ? S_ABORT : S_BEAT_WAIT;
                    end
                end
                S_BEAT_WAIT: begin
                    if (write_q ? !send_empty : !read_full)
                        state_q <= S_ADDR_PH;
                end
                S_ADDR_PH: begin
                    if (write_q)
                        hwdata_q <= send_rdata;
                    state_q <= S_DATA_PH;
                end
                S_DATA_PH: begin
                    if (beat_done) begin
                        remaining_q <= remaining_q - 9'd1;
                        if (remaining_q == 9'd1) begin
                            state_q <= S_IDLE;
                        end else if (beat_err) begin
                            state_q <= S_ABORT;
                        end else begin
                            state_q <= S_BEAT_WAIT;
                            if (incr_q)
                                haddr_q <= haddr_q + (ADDR_WIDTH'(1) << size_q);
                        end
                    end
                end
                S_ABORT: begin
                    // Drain/fill the FIFOs for the remaining beats so the command stream stays aligned.
                    if (abort_xfer) begin
                        remaining_q <= remaining_q - 9'd1;
                        if (remaining_q == 9'd1)
                            state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign send_rinc = nRST && (
                       (((state_q == S_IDLE) || (state_q == S_ADDR_FETCH)) && !send_empty) ||
                       ((state_q == S_ADDR_PH) && write_q) ||
                       ((state_q == S_ABORT) && write_q && !send_empty));

    assign read_winc  = nRST && ((beat_done && !write_q) || (abort_xfer && !write_q));
    assign read_wdata = !read_winc ? '0 :
                        ((state_q == S_DATA_PH) && !beat_err) ? HRDATA : ERR_WORD;

    assign HTRANS = (state_q == S_ADDR_PH) ? 2'b10 : 2'b00;
    assign HADDR  = haddr_q;
    assign HWRITE = write_q;
    assign HSIZE  = {1'b0, size_q};
    assign HWDATA = hwdata_q;
    assign busy   = (state_q != S_IDLE);
    assign err    = err_q;

endmodule

// File: doc/ahb_ap.md
Name: ahb_ap

Overview:
- AHB-Lite access port on the system clock domain.
- Consumes debug command words that the TCK domain writes into the send async FIFO, then performs single-beat AHB-Lite transfers.
- Pushes read data (or error markers) into the read async FIFO, which the AHB FIFO read stage drains on TCK.
- Sits between the FIFO_SEND read side and the FIFO_READ write side.

Parameters:
- DATA_WIDTH, 32, width of AHB data bus and FIFO words
- ADDR_WIDTH, 32, width of HADDR
- ERR_WORD, 32'hBADC0FFE, word pushed to the read FIFO for failed or aborted read beats
- TIMEOUT_CYCLES, 1024, HREADY-low cycles before timeout (used only with the optional feature)

Ports:
- clk  in  1  system clock
- nRST  in  1  synchronous active-low reset
- send_rdata  in  DATA_WIDTH  head word of the send FIFO; first-word-fall-through, valid while send_empty=0
- send_empty  in  1  send FIFO empty
- send_rinc  out  1  pop the send FIFO (one word per cycle asserted)
- read_wdata  out  DATA_WIDTH  word to the read FIFO
- read_full  in  1  read FIFO full
- read_winc  out  1  push read_wdata
- HADDR  out  ADDR_WIDTH  AHB address
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size; bit2 is always 0
- HTRANS  out  2  AHB transfer type; only IDLE=00 and NONSEQ=10 are used
- HWDATA  out  DATA_WIDTH  AHB write data
- HRDATA  in  DATA_WIDTH  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB error response
- err_clr  in  1  clear sticky error flags
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky bus/command error
- timeout  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Command stream, in order:
  - Header word: bit31 = write, bits[29:28] = size (00 byte, 01 half, 10 word, 11 illegal), bit27 = auto-increment, bits[7:0] = beat count minus 1 (1..256 beats).
  - Address word.
  - For writes only: one data word per beat. Data is driven unmodified; lane placement is the host's job.
- Reset: every output is 0, HTRANS=IDLE, state=IDLE, internal counters 0. A reset mid-transfer abandons the current operation immediately; FIFO contents are untouched.
- States: IDLE, ADDR_FETCH, BEAT_WAIT, ADDR_PH, DATA_PH, ABORT.
- IDLE: if send_empty=0, pulse send_rinc and latch the header fields -> ADDR_FETCH.
- ADDR_FETCH: wait for send_empty=0, pulse send_rinc and latch the address.
  - Illegal size: set err, go to ABORT with all beats remaining.
  - Otherwise go to BEAT_WAIT.
- BEAT_WAIT:
  - Write: wait for send_empty=0.
  - Read: wait for read_full=0.
  - Then go to ADDR_PH.
- ADDR_PH (exactly 1 cycle):
  - Drive HTRANS=NONSEQ, HADDR, HWRITE, HSIZE.
  - Write: pulse send_rinc and register the data word into HWDATA for the data phase.
  - Go to DATA_PH.
- DATA_PH:
  - Drive HTRANS=IDLE; HWDATA is held. Wait for HREADY=1.
  - HRESP=0: a read pushes HRDATA (read_winc=1 this cycle).
  - HRESP=1 (two-cycle error response, sampled when HREADY=1): set err; a read pushes ERR_WORD.
  - Decrement remaining. If remaining=0 -> IDLE.
  - Else on error -> ABORT; on success -> BEAT_WAIT, with HADDR += (1<<size) if auto-increment is set (modulo 2^ADDR_WIDTH; no 1KB boundary check).
- ABORT: keeps the FIFO stream aligned.
  - Write: pop one data word per cycle while send_empty=0.
  - Read: push ERR_WORD per cycle while read_full=0.
  - Decrement per word; at 0 -> IDLE. No AHB traffic is issued.
- Latency: with the header visible at cycle N, zero-wait slave and FIFOs ready:
  - header pop N, address pop N+1, BEAT_WAIT N+2, ADDR_PH N+3, data phase/push N+4.
  - Each following beat takes 3 cycles.
- err/timeout: sticky; cleared by err_clr. If set and clear occur in the same cycle, set wins. Flags never stall command processing.
- At most one AHB transfer is outstanding (non-pipelined); HTRANS is never BUSY or SEQ.

Optional Feature:
- Macro: AHB_AP_TIMEOUT_EN.
- Enabled: a counter runs during DATA_PH while HREADY=0. On reaching TIMEOUT_CYCLES it sets timeout and err, treats the beat as an error (read pushes ERR_WORD), then follows the error path.
- Disabled: DATA_PH waits indefinitely and timeout is tied 0.

Test Plan:
- Write 1 word: header 0xA000_0000, addr 0x0000_1000, data 0xCAFEF00D, zero-wait slave -> single NONSEQ write with HADDR=0x1000, HSIZE=2, HWDATA=0xCAFEF00D; 3 send pops; busy low after the data phase.
- Read 4 words auto-increment: header 0x2800_0003, addr 0x2000 -> HADDR 0x2000, 0x2004, 0x2008, 0x200C; 4 pushes matching HRDATA; first push at N+4.
- Read with 2 wait states and read_full held high for 5 cycles before the second beat -> no ADDR_PH while full; all 4 words pushed in order.
- 3-beat write, HRESP error on beat 2 -> err=1; beat 3 data word drained with no AHB access; next command executes normally; err_clr clears err.
- Byte read (size 00), 2 beats, auto-increment at addr 0xFFFF_FFFF -> HADDR 0xFFFF_FFFF then 0x0000_0000, HSIZE=0. Illegal size 11 with count 1 read -> err=1, one ERR_WORD pushed.
- With AHB_AP_TIMEOUT_EN and TIMEOUT_CYCLES=16, HREADY held low -> after 16 cycles timeout=1, err=1, ERR_WORD pushed, state IDLE. Reset asserted mid-DATA_PH -> all outputs 0 the next cycle.
